periph_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one cluster peripheral slave port (event unit or DMA register port) between `NB_REQ` per-core peripheral demux outputs. Requests are forwarded combinationally. Granted requester IDs are queued in an in-order ID FIFO so that each slave response is routed back to the core that issued it. The block sits between the per-core peripheral demuxes and the single shared slave.

---
 rtl/periph_arb_pkg.sv | 33 +++
 rtl/periph_arb_id_fifo.sv | 58 +++++
 rtl/periph_rr_arbiter.sv | 106 ++++++++++
 tb/tb_periph_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_arb_pkg.sv
// Shared types and the round-robin winner search for the peripheral arbiter.
// The requester count is fixed here so that IDs are exactly sized everywhere.
package periph_arb_pkg;

    localparam int ARB_NB_REQ = 8;
    localparam int ARB_ID_W   = (ARB_NB_REQ > 1) ? $clog2(ARB_NB_REQ) : 1;

    typedef logic [ARB_ID_W-1:0] id_t;

    typedef struct packed {
        logic valid;
        id_t  index;
    } rr_win_t;

    // First set bit of req, scanning cyclically upward from ptr (ptr < ARB_NB_REQ).
    function automatic rr_win_t rr_winner(input logic [ARB_NB_REQ-1:0] req, input id_t ptr);
        rr_win_t           res;
        logic [ARB_ID_W:0] idx;
        res = '0;
        for (int i = 0; i < ARB_NB_REQ; i++) begin
            idx = {1'b0, ptr} + (ARB_ID_W+1)'(i);
            if (idx >= (ARB_ID_W+1)'(ARB_NB_REQ)) begin
                idx = idx - (ARB_ID_W+1)'(ARB_NB_REQ);
            end
            if (!res.valid && req[idx[ARB_ID_W-1:0]]) begin
                res.valid = 1'b1;
                res.index = idx[ARB_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/periph_arb_id_fifo.sv
// In-order FIFO of granted requester IDs; the head names the core owed the next response.
module periph_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH-1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH-1)) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin share of one peripheral slave port between the per-core demuxes,
// with responses steered back through an in-order ID FIFO.
module periph_rr_arbiter
    import periph_arb_pkg::*;
#(
    parameter int NB_REQ          = ARB_NB_REQ,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic [NB_REQ-1:0]                    req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
    input  logic [NB_REQ-1:0]                    wen_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NB_REQ-1:0][BE_WIDTH-1:0]      be_i,
    output logic [NB_REQ-1:0]                    gnt_o,
    output logic [NB_REQ-1:0]                    r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic                                 req_o,
    output logic [ADDR_WIDTH-1:0]                add_o,
    output logic                                 wen_o,
    output logic [DATA_WIDTH-1:0]                wdata_o,
    output logic [BE_WIDTH-1:0]                  be_o,
    input  logic                                 gnt_i,
    input  logic                                 r_valid_i,
    input  logic [DATA_WIDTH-1:0]                r_rdata_i,
    input  logic                                 r_opc_i,
    output logic                                 unexp_rsp_o
);

    id_t     r_rr;
    logic    r_unexp;
    rr_win_t w_win;
    id_t     w_sel;
    id_t     w_rr_next;
    id_t     w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_hs;
    logic    w_pop;

    assign w_win = rr_winner(req_i, r_rr);

    // Held off while full even if a pop lands this cycle: no pop-to-push bypass.
    assign req_o = !rst_i && w_win.valid && !w_full;
    assign w_hs  = req_o && gnt_i;
    assign w_sel = req_o ? w_win.index : r_rr;

    assign add_o   = add_i[w_sel];
    assign wen_o   = wen_i[w_sel];
    assign wdata_o = wdata_i[w_sel];
    assign be_o    = be_i[w_sel];

    assign w_rr_next = (w_win.index == id_t'(NB_REQ-1)) ? '0 : w_win.index + id_t'(1);

    always_comb begin
        gnt_o = '0;
        if (w_hs) begin
            gnt_o[w_win.index] = 1'b1;
        end
    end

    periph_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(id_t))
    ) u_id_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .i_push  (w_hs),
        .i_data  (w_win.index),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop     = r_valid_i && !w_empty;
    assign r_rdata_o = r_rdata_i;
    assign r_opc_o   = r_opc_i;

    always_comb begin
        r_valid_o = '0;
        if (w_pop) begin
            r_valid_o[w_head] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rr    <= '0;
            r_unexp <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr <= w_rr_next;
            end
            r_unexp <= r_valid_i && w_empty;
        end
    end

    assign unexp_rsp_o = r_unexp;

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Bench for periph_rr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_periph_rr_arbiter;

    localparam int NB    = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NB-1:0]         req_i = '0;
    logic [NB-1:0][AW-1:0] add_i = '0;
    logic [NB-1:0]         wen_i = '0;
    logic [NB-1:0][DW-1:0] wdata_i = '0;
    logic [NB-1:0][BEW-1:0] be_i = '0;
    logic [NB-1:0]         gnt_o;
    logic [NB-1:0]         r_valid_o;
    logic [DW-1:0]         r_rdata_o;
    logic                  r_opc_o;
    logic                  req_o;
    logic [AW-1:0]         add_o;
    logic                  wen_o;
    logic [DW-1:0]         wdata_o;
    logic [BEW-1:0]        be_o;
    logic                  gnt_i = 1'b0;
    logic                  r_valid_i = 1'b0;
    logic [DW-1:0]         r_rdata_i = '0;
    logic                  r_opc_i = 1'b0;
    logic                  unexp_rsp_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_rr = 0;
    int            m_q[$];
    bit            m_unexp = 1'b0;
    bit            e_req_o;
    bit            e_hs;
    bit            e_pop;
    int            e_win;
    int            e_sel;
    logic [NB-1:0] e_gnt;
    logic [NB-1:0] e_rvalid;

    periph_rr_arbiter #(
        .NB_REQ          (NB),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BE_WIDTH        (BEW),
        .MAX_OUTSTANDING (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_i       (rst),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .req_o       (req_o),
        .add_o       (add_o),
        .wen_o       (wen_o),
        .wdata_o     (wdata_o),
        .be_o        (be_o),
        .gnt_i       (gnt_i),
        .r_valid_i   (r_valid_i),
        .r_rdata_i   (r_rdata_i),
        .r_opc_i     (r_opc_i),
        .unexp_rsp_o (unexp_rsp_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_rr = 0;
        m_q.delete();
        m_unexp = 1'b0;
    endtask

    task automatic eval_model();
        e_win = -1;
        for (int k = 0; k < NB; k++) begin
            int idx;
            idx = (m_rr + k) % NB;
            if (e_win < 0 && req_i[idx]) e_win = idx;
        end
        e_req_o  = !rst && (e_win >= 0) && (m_q.size() < DEPTH);
        e_hs     = e_req_o && gnt_i;
        e_gnt    = e_hs ? (NB'(1) << e_win) : '0;
        e_sel    = e_req_o ? e_win : m_rr;
        e_pop    = !rst && r_valid_i && (m_q.size() > 0);
        e_rvalid = e_pop ? (NB'(1) << m_q[0]) : '0;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_unexp = r_valid_i && (m_q.size() == 0);
            if (e_pop) void'(m_q.pop_front());
            if (e_hs) begin
                m_q.push_back(e_win);
                m_rr = (e_win + 1) % NB;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [NB-1:0] rq, input logic g,
                         input logic rv, input logic [DW-1:0] rd, input logic opc);
        @(negedge clk);
        rst = r; req_i = rq; gnt_i = g; r_valid_i = rv; r_rdata_i = rd; r_opc_i = opc;
        if (r) model_reset();
        #1 eval_model();
    endtask

    task automatic test_reset();
        drive(1'b1, 8'hFF, 1'b1, 1'b1, 32'h0, 1'b0);
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o: got %b want 0", req_o); end
        checks++; if (gnt_o !== 8'h00) begin errors++; $display("FAIL reset_gnt_o: got %h want 00", gnt_o); end
        checks++; if (r_valid_o !== 8'h00) begin errors++; $display("FAIL reset_r_valid_o: got %h want 00", r_valid_o); end
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %b want 0", unexp_rsp_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_release_unexp: got %b want 0", unexp_rsp_o); end
        clock_edge();
    endtask

    task automatic test_single_read();
        for (int i = 0; i < NB; i++) add_i[i] = 32'h2000_0000 + 32'(i * 16);
        add_i[3] = 32'h1020_4000;
        wen_i    = 8'h08;
        drive(1'b0, 8'h08, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (gnt_o !== 8'h08) begin errors++; $display("FAIL single_gnt: got %h want 08", gnt_o); end
        checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_req_o: got %b want 1", req_o); end
        checks++; if (add_o !== 32'h1020_4000) begin errors++; $display("FAIL single_add: got %h want 10204000", add_o); end
        checks++; if (wen_o !== 1'b1) begin errors++; $display("FAIL single_wen: got %b want 1", wen_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (r_valid_o !== 8'h00) begin errors++; $display("FAIL single_idle_rvalid: got %h want 00", r_valid_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checks++; if (r_valid_o !== 8'h08) begin errors++; $display("FAIL single_rvalid: got %h want 08", r_valid_o); end
        checks++; if (r_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", r_rdata_o); end
        clock_edge();
        // Pointer now at 4: requesters 3 and 4 compete, 4 wins.
        drive(1'b0, 8'h18, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (gnt_o !== 8'h10) begin errors++; $display("FAIL single_rr_after: got %h want 10", gnt_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h1234, 1'b0);
        checks++; if (r_valid_o !== 8'h10) begin errors++; $display("FAIL single_rvalid2: got %h want 10", r_valid_o); end
        clock_edge();
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] want;
        drive(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        clock_edge();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, (k < 9) ? 8'hFF : 8'h00, k < 9, k > 0, 32'(k), 1'b0);
            want = (k < 9) ? (NB'(1) << (k % NB)) : '0;
            checks++; if (gnt_o !== want) begin errors++; $display("FAIL b2b_gnt[%0d]: got %h want %h", k, gnt_o, want); end
            want = (k > 0) ? (NB'(1) << ((k - 1) % NB)) : '0;
            checks++; if (r_valid_o !== want) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %h want %h", k, r_valid_o, want); end
            clock_edge();
        end
    endtask

    task automatic test_full();
        logic [NB-1:0] want;
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
            want = NB'(1) << (k + 1);
            checks++; if (gnt_o !== want) begin errors++; $display("FAIL full_fill_gnt[%0d]: got %h want %h", k, gnt_o, want); end
            clock_edge();
        end
        drive(1'b0, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL full_req_o: got %b want 0", req_o); end
        checks++; if (gnt_o !== 8'h00) begin errors++; $display("FAIL full_gnt: got %h want 00", gnt_o); end
        clock_edge();
        drive(1'b0, 8'hFF, 1'b1, 1'b1, 32'h0, 1'b0);
        checks++; if (r_valid_o !== 8'h02) begin errors++; $display("FAIL full_pop_rvalid: got %h want 02", r_valid_o); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL full_no_bypass_req: got %b want 0", req_o); end
        checks++; if (gnt_o !== 8'h00) begin errors++; $display("FAIL full_no_bypass_gnt: got %h want 00", gnt_o); end
        clock_edge();
        drive(1'b0, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL full_resume_req: got %b want 1", req_o); end
        checks++; if (gnt_o !== 8'h20) begin errors++; $display("FAIL full_resume_gnt: got %h want 20", gnt_o); end
        clock_edge();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0);
            want = NB'(1) << (k + 2);
            checks++; if (r_valid_o !== want) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", k, r_valid_o, want); end
            clock_edge();
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 8'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (gnt_o !== 8'h40) begin errors++; $display("FAIL wrap_pre_gnt: got %h want 40", gnt_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0);
        clock_edge();
        drive(1'b0, 8'h42, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (gnt_o !== 8'h02) begin errors++; $display("FAIL wrap_gnt: got %h want 02", gnt_o); end
        clock_edge();
        drive(1'b0, 8'h06, 1'b1, 1'b1, 32'h0, 1'b1);
        checks++; if (gnt_o !== 8'h04) begin errors++; $display("FAIL wrap_rr_next: got %h want 04", gnt_o); end
        checks++; if (r_valid_o !== 8'h02) begin errors++; $display("FAIL wrap_rvalid: got %h want 02", r_valid_o); end
        checks++; if (r_opc_o !== 1'b1) begin errors++; $display("FAIL wrap_opc: got %b want 1", r_opc_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0);
        checks++; if (r_valid_o !== 8'h04) begin errors++; $display("FAIL wrap_rvalid2: got %h want 04", r_valid_o); end
        clock_edge();
    endtask

    task automatic test_unexpected();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0);
        checks++; if (r_valid_o !== 8'h00) begin errors++; $display("FAIL unexp_rvalid: got %h want 00", r_valid_o); end
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_early: got %b want 0", unexp_rsp_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_pulse: got %b want 1", unexp_rsp_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_clear: got %b want 0", unexp_rsp_o); end
        clock_edge();
    endtask

    task automatic test_reset_mid();
        logic want;
        drive(1'b0, 8'h01, 1'b1, 1'b0, 32'h0, 1'b0);
        clock_edge();
        drive(1'b0, 8'h02, 1'b1, 1'b0, 32'h0, 1'b0);
        clock_edge();
        drive(1'b1, 8'h04, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL midrst_req_o: got %b want 0", req_o); end
        clock_edge();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'h00, 1'b0, k < 2, 32'h0, 1'b0);
            want = (k == 1 || k == 2);
            checks++; if (r_valid_o !== 8'h00) begin errors++; $display("FAIL midrst_rvalid[%0d]: got %h want 00", k, r_valid_o); end
            checks++; if (unexp_rsp_o !== want) begin errors++; $display("FAIL midrst_unexp[%0d]: got %b want %b", k, unexp_rsp_o, want); end
            clock_edge();
        end
        drive(1'b0, 8'h81, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (gnt_o !== 8'h01) begin errors++; $display("FAIL midrst_rr_zero: got %h want 01", gnt_o); end
        clock_edge();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0);
        clock_edge();
    endtask

    task automatic test_random();
        logic [NB-1:0] rq;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB; i++) begin
                add_i[i]   = $urandom;
                wdata_i[i] = $urandom;
                be_i[i]    = BEW'($urandom);
            end
            wen_i = NB'($urandom);
            rq = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
            drive($urandom_range(0, 99) == 0, rq, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1) == 1, $urandom, 1'($urandom));
            checks++; if (req_o !== e_req_o) begin errors++; $display("FAIL rnd_req_o[%0d]: got %b want %b", c, req_o, e_req_o); end
            checks++; if (gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d]: got %h want %h", c, gnt_o, e_gnt); end
            checks++; if (r_valid_o !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %h want %h", c, r_valid_o, e_rvalid); end
            checks++; if (unexp_rsp_o !== m_unexp) begin errors++; $display("FAIL rnd_unexp[%0d]: got %b want %b", c, unexp_rsp_o, m_unexp); end
            checks++; if (add_o !== add_i[e_sel]) begin errors++; $display("FAIL rnd_add[%0d]: got %h want %h", c, add_o, add_i[e_sel]); end
            checks++; if (wen_o !== wen_i[e_sel]) begin errors++; $display("FAIL rnd_wen[%0d]: got %b want %b", c, wen_o, wen_i[e_sel]); end
            checks++; if (wdata_o !== wdata_i[e_sel]) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, wdata_o, wdata_i[e_sel]); end
            checks++; if (be_o !== be_i[e_sel]) begin errors++; $display("FAIL rnd_be[%0d]: got %h want %h", c, be_o, be_i[e_sel]); end
            checks++; if (r_rdata_o !== r_rdata_i || r_opc_o !== r_opc_i) begin
                errors++; $display("FAIL rnd_rsp_bcast[%0d]: got %h/%b want %h/%b", c, r_rdata_o, r_opc_o, r_rdata_i, r_opc_i);
            end
            clock_edge();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_full();
        test_wrap();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
